// File: rtl/osd_status_udp_tx.sv
// Formats channel/angle/scale as a 23-byte ASCII status line and streams it as one UDP payload.
// Optional build macro STATUS_TX_CHANGE_ONLY_EN: timer sends only when the status changed since the last frame.
module osd_status_udp_tx #(
  parameter logic [31:0] PERIOD_CYCLES = 32'd125_000_000,
  parameter logic [15:0] PAYLOAD_LEN   = 16'd23
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        send_trig,
  input  logic [2:0]  channel_index,
  input  logic [8:0]  angle_num,
  input  logic [10:0] scale_value,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  output logic [15:0] udp_tx_len,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  input  logic        udp_tx_ready,
  output logic        udp_tx_last,
  output logic        tx_busy
);

  localparam int unsigned LAST_IDX  = 22;
  localparam int unsigned CONV_LAST = 30;

  typedef enum logic [1:0] {IDLE, CONV, REQ, SEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic        pend_q, pend_d;
  logic [2:0]  ch_q, ch_d;
  logic [8:0]  ang_q, ang_d;
  logic [10:0] scl_q, scl_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [8:0]  src_a_q, src_a_d;
  logic [6:0]  src_i_q, src_i_d;
  logic [13:0] src_f_q, src_f_d;
  logic [11:0] bcd_a_q, bcd_a_d;
  logic [11:0] bcd_i_q, bcd_i_d;
  logic [15:0] bcd_f_q, bcd_f_d;
  logic        req_q, req_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
`ifdef STATUS_TX_CHANGE_ONLY_EN
  logic [22:0] cmp_q, cmp_d;
  logic        cmp_vld_q, cmp_vld_d;
`endif

  logic        wrap;
  logic        wrap_send;
  logic        pend_set;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic b);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[14:0], b};
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pend_d    = pend_q;
    ch_d      = ch_q;
    ang_d     = ang_q;
    scl_d     = scl_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    src_a_d   = src_a_q;
    src_i_d   = src_i_q;
    src_f_d   = src_f_q;
    bcd_a_d   = bcd_a_q;
    bcd_i_d   = bcd_i_q;
    bcd_f_d   = bcd_f_q;
    req_d     = 1'b0;
    len_d     = 16'd0;
    data_d    = 8'd0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    wrap      = 1'b0;
    wrap_send = 1'b0;
    pend_set  = 1'b0;
`ifdef STATUS_TX_CHANGE_ONLY_EN
    cmp_d     = cmp_q;
    cmp_vld_d = cmp_vld_q;
`endif

    // Free-running period timer; a zero period disables it entirely.
    if (PERIOD_CYCLES != 32'd0) begin
      wrap  = (tmr_q == PERIOD_CYCLES - 32'd1);
      tmr_d = wrap ? 32'd0 : tmr_q + 32'd1;
    end else begin
      tmr_d = 32'd0;
    end

`ifdef STATUS_TX_CHANGE_ONLY_EN
    wrap_send = wrap && (!cmp_vld_q || ({channel_index, angle_num, scale_value} != cmp_q));
`else
    wrap_send = wrap;
`endif
    pend_set = send_trig | wrap_send;
    pend_d   = pend_q | pend_set;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = pend_set;
          ch_d    = channel_index;
          ang_d   = angle_num;
          scl_d   = scale_value;
          cnt_d   = 5'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Step 0 loads the sources; then 9 angle, 7 integer and 14 fraction shifts in turn.
        if (cnt_q == 5'd0) begin
          src_a_d = ang_q;
          src_i_d = scl_q[10:4];
          src_f_d = 14'(scl_q[3:0]) * 14'd625;
          bcd_a_d = 12'd0;
          bcd_i_d = 12'd0;
          bcd_f_d = 16'd0;
        end else if (cnt_q <= 5'd9) begin
          bcd_a_d = 12'(dd_step({4'd0, bcd_a_q}, src_a_q[8]));
          src_a_d = {src_a_q[7:0], 1'b0};
        end else if (cnt_q <= 5'd16) begin
          bcd_i_d = 12'(dd_step({4'd0, bcd_i_q}, src_i_q[6]));
          src_i_d = {src_i_q[5:0], 1'b0};
        end else begin
          bcd_f_d = dd_step(bcd_f_q, src_f_q[13]);
          src_f_d = {src_f_q[12:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(CONV_LAST)) state_d = REQ;
      end
      REQ: begin
        if (udp_tx_ack) begin
          idx_d   = 5'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && udp_tx_ready) begin
          if (idx_q == 5'(LAST_IDX)) begin
            state_d = IDLE;
`ifdef STATUS_TX_CHANGE_ONLY_EN
            cmp_d     = {ch_q, ang_q, scl_q};
            cmp_vld_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d   = (state_d == REQ);
    len_d   = req_d ? PAYLOAD_LEN : 16'd0;
    valid_d = (state_d == SEND);
    last_d  = valid_d && (idx_d == 5'(LAST_IDX));
    busy_d  = (state_d != IDLE);
    if (valid_d) begin
      case (idx_d)
        5'd0:    data_d = 8'h43;
        5'd1:    data_d = 8'h48;
        5'd2:    data_d = 8'h3D;
        5'd3:    data_d = asc({1'b0, ch_q});
        5'd4:    data_d = 8'h20;
        5'd5:    data_d = 8'h41;
        5'd6:    data_d = 8'h3D;
        5'd7:    data_d = asc(bcd_a_q[11:8]);
        5'd8:    data_d = asc(bcd_a_q[7:4]);
        5'd9:    data_d = asc(bcd_a_q[3:0]);
        5'd10:   data_d = 8'h20;
        5'd11:   data_d = 8'h53;
        5'd12:   data_d = 8'h3D;
        5'd13:   data_d = asc(bcd_i_q[11:8]);
        5'd14:   data_d = asc(bcd_i_q[7:4]);
        5'd15:   data_d = asc(bcd_i_q[3:0]);
        5'd16:   data_d = 8'h2E;
        5'd17:   data_d = asc(bcd_f_q[15:12]);
        5'd18:   data_d = asc(bcd_f_q[11:8]);
        5'd19:   data_d = asc(bcd_f_q[7:4]);
        5'd20:   data_d = asc(bcd_f_q[3:0]);
        5'd21:   data_d = 8'h0D;
        5'd22:   data_d = 8'h0A;
        default: data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= 32'd0;
      pend_q    <= 1'b0;
      ch_q      <= 3'd0;
      ang_q     <= 9'd0;
      scl_q     <= 11'd0;
      cnt_q     <= 5'd0;
      idx_q     <= 5'd0;
      src_a_q   <= 9'd0;
      src_i_q   <= 7'd0;
      src_f_q   <= 14'd0;
      bcd_a_q   <= 12'd0;
      bcd_i_q   <= 12'd0;
      bcd_f_q   <= 16'd0;
      req_q     <= 1'b0;
      len_q     <= 16'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef STATUS_TX_CHANGE_ONLY_EN
      cmp_q     <= 23'd0;
      cmp_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      ch_q      <= ch_d;
      ang_q     <= ang_d;
      scl_q     <= scl_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      src_a_q   <= src_a_d;
      src_i_q   <= src_i_d;
      src_f_q   <= src_f_d;
      bcd_a_q   <= bcd_a_d;
      bcd_i_q   <= bcd_i_d;
      bcd_f_q   <= bcd_f_d;
      req_q     <= req_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
`ifdef STATUS_TX_CHANGE_ONLY_EN
      cmp_q     <= cmp_d;
      cmp_vld_q <= cmp_vld_d;
`endif
    end
  end

  assign udp_tx_req   = req_q;
  assign udp_tx_len   = len_q;
  assign udp_tx_data  = data_q;
  assign udp_tx_valid = valid_q;
  assign udp_tx_last  = last_q;
  assign tx_busy      = busy_q;

endmodule

// File: tb/tb_osd_status_udp_tx.sv
// Bench for osd_status_udp_tx: table vectors, random frames vs an arithmetic model, and timer behaviour.
module tb_osd_status_udp_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with timer disabled, driven by the test sequences
  logic        rst0, trig0, ack0, ready0;
  logic [2:0]  ch0;
  logic [8:0]  ang0;
  logic [10:0] scl0;
  logic        req0, valid0, last0, busy0;
  logic [15:0] len0;
  logic [7:0]  data0;

  // DUT with a 200-cycle period, serviced by an automatic responder
  logic        rst1, ack1;
  logic        trig1  = 1'b0;
  logic        ready1 = 1'b1;
  logic [2:0]  ch1;
  logic [8:0]  ang1;
  logic [10:0] scl1;
  logic        req1, valid1, last1, busy1;
  logic [15:0] len1;
  logic [7:0]  data1;

  osd_status_udp_tx #(.PERIOD_CYCLES(32'd0), .PAYLOAD_LEN(16'd23)) dut (
    .sys_clk(clk), .rst(rst0), .send_trig(trig0),
    .channel_index(ch0), .angle_num(ang0), .scale_value(scl0),
    .udp_tx_req(req0), .udp_tx_ack(ack0), .udp_tx_len(len0),
    .udp_tx_data(data0), .udp_tx_valid(valid0), .udp_tx_ready(ready0),
    .udp_tx_last(last0), .tx_busy(busy0));

  osd_status_udp_tx #(.PERIOD_CYCLES(32'd200), .PAYLOAD_LEN(16'd23)) dut_tmr (
    .sys_clk(clk), .rst(rst1), .send_trig(trig1),
    .channel_index(ch1), .angle_num(ang1), .scale_value(scl1),
    .udp_tx_req(req1), .udp_tx_ack(ack1), .udp_tx_len(len1),
    .udp_tx_data(data1), .udp_tx_valid(valid1), .udp_tx_ready(ready1),
    .udp_tx_last(last1), .tx_busy(busy1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dig(input int v);
    return 8'(32'h30 + v);
  endfunction

  // Reference line built with decimal arithmetic straight from the message format
  function automatic logic [183:0] model_frame(input logic [2:0] c, input logic [8:0] a, input logic [10:0] s);
    int ci, ai, ip, fv;
    ci = int'(c);
    ai = int'(a);
    ip = int'(s) / 16;
    fv = (int'(s) % 16) * 625;
    return {"CH=", dig(ci), " A=", dig(ai / 100), dig((ai / 10) % 10), dig(ai % 10),
            " S=", dig(ip / 100), dig((ip / 10) % 10), dig(ip % 10), ".",
            dig(fv / 1000), dig((fv / 100) % 10), dig((fv / 10) % 10), dig(fv % 10),
            8'h0D, 8'h0A};
  endfunction

  logic [2:0]  mid_ch;
  logic [8:0]  mid_ang;
  logic [10:0] mid_scl;

  // Waits for req, acks after ack_dly cycles, collects one frame and checks it; starts and ends on a negedge.
  task automatic run_frame(input string name, input logic [183:0] exp, input bit rnd_ready,
                           input int ack_dly, input bit mid);
    int t, n, last_at, last_cnt, stall_err;
    bit stall_prev;
    logic [7:0] pd;
    logic [183:0] got;
    logic [7:0] gb, eb;
    t = 0; n = 0; last_at = -1; last_cnt = 0; stall_err = 0; stall_prev = 1'b0;
    pd = 8'd0; got = '0;
    while (!req0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_req"}, 32'(req0), 32'd1);
    if (!req0) return;
    check({name, "_len"}, 32'(len0), 32'd23);
    repeat (ack_dly) @(negedge clk);
    check({name, "_req_hold"}, 32'(req0), 32'd1);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    check({name, "_req_drop"}, 32'(req0), 32'd0);
    t = 0;
    while (n < 23 && t < 3000) begin
      trig0 = 1'b0;
      if (stall_prev && (!valid0 || data0 !== pd)) stall_err++;
      ready0 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid0 && ready0) begin
        if (mid && (n == 10 || n == 15)) trig0 = 1'b1;
        if (mid && n == 12) begin
          ch0 = mid_ch; ang0 = mid_ang; scl0 = mid_scl;
        end
        got[8*(22-n) +: 8] = data0;
        if (last0) begin
          last_at = n;
          last_cnt++;
        end
        n++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = valid0;
        pd = data0;
      end
      @(negedge clk);
      t++;
    end
    trig0 = 1'b0;
    ready0 = 1'b1;
    check({name, "_beats"}, 32'(n), 32'd23);
    check({name, "_last_pos"}, 32'(last_at), 32'd22);
    check({name, "_last_cnt"}, 32'(last_cnt), 32'd1);
    check({name, "_stall_stable"}, 32'(stall_err), 32'd0);
    check({name, "_valid_end"}, 32'(valid0), 32'd0);
    check({name, "_busy_fall"}, 32'(busy0), 32'd0);
    for (int i = 0; i < 23; i++) begin
      gb = got[8*(22-i) +: 8];
      eb = exp[8*(22-i) +: 8];
      check($sformatf("%s_byte%0d", name, i), 32'(gb), 32'(eb));
    end
  endtask

  typedef struct {
    logic [2:0]   ch;
    logic [8:0]   ang;
    logic [10:0]  scl;
    bit           rnd_ready;
    int           ack_dly;
    logic [183:0] exp;
  } vec_t;

  // Timer-DUT responder and frame monitor
  int rises[$];
  logic [183:0] frames[$];
  initial begin
    int fn;
    logic [183:0] fr;
    logic req1_prev;
    fn = 0; fr = '0; req1_prev = 1'b0; ack1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        ack1 = 1'b0; req1_prev = 1'b0; fn = 0;
      end else begin
        if (req1 && !req1_prev) rises.push_back(cyc);
        req1_prev = req1;
        ack1 = req1 && !ack1;
        if (valid1) begin
          if (fn < 23) fr[8*(22-fn) +: 8] = data1;
          fn++;
          if (last1) begin
            frames.push_back(fr);
            fn = 0;
            fr = '0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int t, n, bad;
    logic [2:0] rc;
    logic [8:0] ra;
    logic [10:0] rs;
    vecs[0] = '{3'd3, 9'd45,  11'h028, 1'b0, 2, "CH=3 A=045 S=002.5000\015\012"};
    vecs[1] = '{3'd7, 9'd511, 11'h7FF, 1'b1, 0, "CH=7 A=511 S=127.9375\015\012"};
    vecs[2] = '{3'd0, 9'd0,   11'h000, 1'b0, 4, "CH=0 A=000 S=000.0000\015\012"};
    vecs[3] = '{3'd5, 9'd100, 11'h1A3, 1'b1, 1, "CH=5 A=100 S=026.1875\015\012"};
    vecs[4] = '{3'd1, 9'd99,  11'h641, 1'b1, 3, "CH=1 A=099 S=100.0625\015\012"};

    rst0 = 1'b1; rst1 = 1'b1; trig0 = 1'b0; ack0 = 1'b0; ready0 = 1'b1;
    ch0 = 3'd0; ang0 = 9'd0; scl0 = 11'd0;
    ch1 = 3'd3; ang1 = 9'd200; scl1 = 11'h2C4;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({req0, len0, data0, valid0, last0, busy0}), 32'd0);
    check("reset_outs_tmr", 32'({req1, len1, data1, valid1, last1, busy1}), 32'd0);
    rst0 = 1'b0;
    @(negedge clk);

    // Ack while idle must not start anything
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (req0 || busy0 || valid0) bad++;
    end
    check("stray_ack_ignored", 32'(bad), 32'd0);

    for (int i = 0; i < 5; i++) begin
      ch0 = vecs[i].ch; ang0 = vecs[i].ang; scl0 = vecs[i].scl;
      trig0 = 1'b1;
      @(negedge clk);
      trig0 = 1'b0;
      run_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].rnd_ready, vecs[i].ack_dly, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = 9'($urandom_range(0, 511));
      rs = 11'($urandom_range(0, 2047));
      ch0 = rc; ang0 = ra; scl0 = rs;
      trig0 = 1'b1;
      @(negedge clk);
      trig0 = 1'b0;
      run_frame($sformatf("rnd%0d", i), model_frame(rc, ra, rs), 1'b1, $urandom_range(0, 4), 1'b0);
    end

    // Triggers at bytes 10 and 15 collapse into one follow-up frame carrying the new inputs
    ch0 = 3'd2; ang0 = 9'd300; scl0 = 11'h155;
    mid_ch = 3'd6; mid_ang = 9'd77; mid_scl = 11'h0F3;
    trig0 = 1'b1;
    @(negedge clk);
    trig0 = 1'b0;
    run_frame("mid_first", model_frame(3'd2, 9'd300, 11'h155), 1'b0, 1, 1'b1);
    run_frame("mid_second", model_frame(3'd6, 9'd77, 11'h0F3), 1'b1, 2, 1'b0);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (req0 || busy0) bad++;
    end
    check("mid_no_third", 32'(bad), 32'd0);

    // Reset during SEND after 5 accepted bytes
    ch0 = 3'd4; ang0 = 9'd123; scl0 = 11'h3A7;
    trig0 = 1'b1;
    @(negedge clk);
    trig0 = 1'b0;
    t = 0;
    while (!req0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rst_req", 32'(req0), 32'd1);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    n = 0; t = 0;
    while (n < 5 && t < 200) begin
      ready0 = 1'b1;
      if (valid0) n++;
      @(negedge clk);
      t++;
    end
    check("rst_beats_before", 32'(n), 32'd5);
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_outs_low", 32'({valid0, req0, last0, busy0}), 32'd0);
    rst0 = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_stays_idle", 32'({valid0, req0, busy0}), 32'd0);
    ch0 = 3'd6; ang0 = 9'd321; scl0 = 11'h5B9;
    trig0 = 1'b1;
    @(negedge clk);
    trig0 = 1'b0;
    run_frame("after_rst", model_frame(3'd6, 9'd321, 11'h5B9), 1'b0, 2, 1'b0);

    // Timer-driven sends
    rst1 = 1'b0;
`ifdef STATUS_TX_CHANGE_ONLY_EN
    repeat (650) @(negedge clk);
    check("tmr_first_only", 32'(rises.size()), 32'd1);
    check("tmr_frames1", 32'(frames.size()), 32'd1);
    if (frames.size() >= 1) check_frame("tmr_frame0", frames[0], model_frame(3'd3, 9'd200, 11'h2C4));
    ang1 = 9'd90;
    repeat (400) @(negedge clk);
    check("tmr_change_send", 32'(rises.size()), 32'd2);
    check("tmr_frames2", 32'(frames.size()), 32'd2);
    if (frames.size() >= 2) check_frame("tmr_frame1", frames[1], model_frame(3'd3, 9'd90, 11'h2C4));
`else
    repeat (900) @(negedge clk);
    check("tmr_rises", 32'(rises.size() >= 3), 32'd1);
    if (rises.size() >= 3) begin
      check("tmr_period0", 32'(rises[1] - rises[0]), 32'd200);
      check("tmr_period1", 32'(rises[2] - rises[1]), 32'd200);
    end
    check("tmr_frames", 32'(frames.size() >= 3), 32'd1);
    if (frames.size() >= 1) check_frame("tmr_frame0", frames[0], model_frame(3'd3, 9'd200, 11'h2C4));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_status_udp_tx.md
Name: osd_status_udp_tx

Overview:
- Transmit-side companion to the UDP character receive path.
- Takes the OSD status values (channel index, angle, scale), formats them as a fixed 23-byte ASCII line and streams it as one UDP payload to the Ethernet UDP transmit stack.
- A send is started by a periodic timer or by an explicit trigger pulse.
- Sits in the sys_clk domain beside the Ethernet test/UDP block.

Parameters:
- PERIOD_CYCLES, 32'd125_000_000, sys_clk cycles between automatic sends; 0 disables the timer.
- PAYLOAD_LEN, 16'd23, fixed payload length in bytes; must equal the message format below.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- send_trig  in  1  one-cycle request for an immediate send.
- channel_index  in  3  current channel, 0..7.
- angle_num  in  9  angle, 0..511.
- scale_value  in  11  [10:4] integer part, [3:0] fraction in 1/16 steps.
- udp_tx_req  out  1  payload request to the UDP stack.
- udp_tx_ack  in  1  stack grant (one-cycle pulse).
- udp_tx_len  out  16  payload length; equals PAYLOAD_LEN while udp_tx_req is high.
- udp_tx_data  out  8  payload byte.
- udp_tx_valid  out  1  udp_tx_data is valid.
- udp_tx_ready  in  1  stack accepts the byte when valid and ready are both high.
- udp_tx_last  out  1  marks the final byte, concurrent with valid.
- tx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0. Timer cleared, FSM in IDLE, pending flag cleared.
- Reset mid-operation: on the next edge the FSM goes to IDLE and valid/req drop. No partial frame is resumed.
- Timer:
  - Counts 0..PERIOD_CYCLES-1 continuously and sets pending on wrap.
  - send_trig also sets pending.
  - Trigger or wrap while busy: pending is held, and one send follows the current one. Multiple pending events collapse into one.
- FSM states and transitions:
  - IDLE: if pending, clear pending, latch all three inputs, go to CONV.
  - CONV: sequential double-dabble, one shift per cycle.
    - angle_num: 9 shifts, giving 3 BCD digits.
    - scale integer: 7 shifts, giving 3 BCD digits.
    - scale fraction: frac*625 (14-bit, max 9375), 14 shifts, giving 4 BCD digits.
    - Total 30 cycles plus 1 setup cycle, then go to REQ.
  - REQ: udp_tx_req=1 and udp_tx_len=PAYLOAD_LEN. On udp_tx_ack: drop req next cycle, set byte index to 0, go to SEND.
  - SEND: udp_tx_valid=1, udp_tx_data=byte[idx].
    - On valid&&ready: increment idx.
    - udp_tx_last=1 when idx==22.
    - On the accepted last byte, go to IDLE.
    - valid never drops and data never changes while ready is low.
- Message (ASCII): "CH=" c " A=" aaa " S=" iii "." ffff CR LF, 23 bytes.
  - Digits are 0x30+BCD with leading zeros kept.
  - CR=0x0D, LF=0x0A.
- Input changes after the latch do not affect the frame in flight.
- ack outside REQ is ignored.

Optional Feature:
- Macro: STATUS_TX_CHANGE_ONLY_EN.
- Defined:
  - The timer wrap sets pending only if {channel_index, angle_num, scale_value} differs from the value latched for the last completed send.
  - send_trig always sets pending.
  - The compare register is cleared by reset, so the first wrap after reset always sends.
- Undefined: every timer wrap sends unconditionally.

Test Plan:
- Basic format: ch=3, angle=45, scale=11'h028, send_trig pulse, ack after 2 cycles, ready always 1 -> 23 bytes "CH=3 A=045 S=002.5000\r\n"; last on byte 23; tx_busy falls the cycle after.
- Maximum values: ch=7, angle=511, scale=11'h7FF -> "CH=7 A=511 S=127.9375\r\n".
- Backpressure: toggle ready pseudo-randomly -> byte sequence unchanged; data/valid stable while ready=0; exactly 23 accepted beats.
- Trigger during send: send_trig at byte 10 and again at byte 15 -> exactly one further frame after the first; inputs changed mid-frame appear only in the second frame.
- Timer: PERIOD_CYCLES=200, no trig -> req every 200 cycles. With STATUS_TX_CHANGE_ONLY_EN defined and inputs static -> one frame after reset, then none until angle changes to 90 -> next wrap sends "A=090".
- Reset mid-SEND at byte 5 -> valid/req/last/busy low the next cycle; the next trigger produces a complete, correct 23-byte frame.
